// File: rtl/oam_dma_arbiter_pkg.sv
// Shared address map, DMA constants and types for the OAM DMA arbiter.
// Holds the FSM state enum, the DMA bus request bundle and the echo mapping helper.
package oam_dma_arbiter_pkg;

    localparam int unsigned DMA_LEN      = 160;
    localparam logic [7:0]  LAST_IDX     = 8'(DMA_LEN - 1);
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_START   = 16'hFF80;
    localparam logic [15:0] HRAM_END     = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } dma_state_t;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } dma_req_t;

    // E0..FF sources alias the WRAM echo region down by 0x20 pages.
    function automatic logic [7:0] src_eff(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: FSM, byte index, source register, read-to-write byte latch.
// Ports: i_start/i_src (register write), i_stall, i_rdata in; o_req, o_src, o_active, o_done out.
module oam_dma_engine
    import oam_dma_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_src,
    input  logic       i_stall,
    input  logic [7:0] i_rdata,
    output dma_req_t   o_req,
    output logic [7:0] o_src,
    output logic       o_active,
    output logic       o_done
);

    dma_state_t r_state;
    dma_state_t w_state_next;
    logic [7:0] r_idx;
    logic [7:0] w_idx_next;
    logic [7:0] r_latch;
    logic [7:0] w_latch_next;
    logic [7:0] r_src;
    logic [7:0] w_src_next;
    logic       r_done;
    logic       w_done_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
            r_src   <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_latch <= w_latch_next;
            r_src   <= w_src_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_latch_next = r_latch;
        w_src_next   = r_src;
        w_done_next  = 1'b0;
        o_req        = '0;
        unique case (r_state)
            IDLE: ;
            START: begin
                if (!i_stall) w_state_next = READ;
            end
            READ: begin
                o_req.re   = 1'b1;
                o_req.addr = {src_eff(r_src), r_idx};
                if (!i_stall) begin
                    w_latch_next = i_rdata;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                o_req.we   = 1'b1;
                o_req.addr = OAM_BASE + {8'h00, r_idx};
                o_req.data = r_latch;
                if (!i_stall) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next   = r_idx + 8'd1;
                        w_state_next = READ;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        // The bus access above still happens this cycle; restart wins the next state.
        if (i_start) begin
            w_src_next   = i_src;
            w_idx_next   = 8'h00;
            w_state_next = START;
            w_done_next  = 1'b0;
        end
    end

    assign o_src    = r_src;
    assign o_active = (r_state != IDLE);
    assign o_done   = r_done;

endmodule

// File: rtl/oam_dma_arbiter.sv
// Bus arbiter between the CPU and the OAM DMA engine in front of the bus decoder.
// Ports: cpu_* from the CPU, mem_* to the decoder, dma_active/dma_done status.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active,
    output logic        dma_done
);

    dma_req_t   w_req;
    logic [7:0] w_src;
    logic       w_is_reg;
    logic       w_is_hram;
    logic       w_hram_win;
    logic       w_cpu_bus;
    logic       w_dma_bus;

    assign w_is_reg   = (cpu_addr == DMA_REG_ADDR);
    assign w_is_hram  = (cpu_addr >= HRAM_START) && (cpu_addr <= HRAM_END);
    // HRAM access steals the bus during a transfer; the engine stalls.
    assign w_hram_win = dma_active && w_is_hram
                        && (cpu_read_en || cpu_write_en);
    assign w_dma_bus  = dma_active && !w_hram_win;
    assign w_cpu_bus  = (!dma_active && !w_is_reg) || w_hram_win;

    oam_dma_engine u_engine (
        .clk      (clk),
        .reset    (reset),
        .i_start  (cpu_write_en && w_is_reg),
        .i_src    (cpu_wdata),
        .i_stall  (w_hram_win),
        .i_rdata  (mem_rdata),
        .o_req    (w_req),
        .o_src    (w_src),
        .o_active (dma_active),
        .o_done   (dma_done)
    );

    always_comb begin
        mem_addr     = 16'h0000;
        mem_wdata    = 8'h00;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        if (w_dma_bus) begin
            mem_addr     = w_req.addr;
            mem_wdata    = w_req.data;
            mem_read_en  = w_req.re;
            mem_write_en = w_req.we;
        end else if (w_cpu_bus) begin
            mem_addr     = cpu_addr;
            mem_wdata    = cpu_wdata;
            mem_read_en  = cpu_read_en;
            mem_write_en = cpu_write_en;
        end
    end

    always_comb begin
        cpu_rdata = 8'hFF;
        if (w_is_reg) begin
            cpu_rdata = w_src;
        end else if (w_cpu_bus) begin
            cpu_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed self-checking bench for oam_dma_arbiter with a 64 KiB bus memory model.
// Covers reset abort, full copy timing, blocked CPU access, HRAM stall, restart, echo.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [7:0]  mem_rdata;
    logic        dma_active;
    logic        dma_done;

    bit [7:0] mem [0:65535];
    int       wcnt;
    int       dcnt;
    int       checks;
    int       fails;

    oam_dma_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_read_en  (cpu_read_en),
        .cpu_write_en (cpu_write_en),
        .cpu_rdata    (cpu_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata),
        .dma_active   (dma_active),
        .dma_done     (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr] <= mem_wdata;
            wcnt <= wcnt + 1;
        end
        if (dma_done) dcnt <= dcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr     = a;
        cpu_wdata    = d;
        cpu_write_en = 1'b1;
        step();
        cpu_write_en = 1'b0;
    endtask

    // Steps until dma_done is seen; returns edges taken (400 if never seen).
    task automatic run_to_done(output int n);
        n = 0;
        while (n < 400) begin
            step();
            n++;
            if (dma_done) break;
        end
    endtask

    function automatic int oam_errs(input int kind);
        int e;
        logic [7:0] x;
        e = 0;
        for (int i = 0; i < 160; i++) begin
            case (kind)
                0:       x = 8'(i) ^ 8'h5A;
                1:       x = 8'(i) ^ 8'hA5;
                default: x = 8'(i) + 8'd3;
            endcase
            if (mem[16'hFE00 + 16'(i)] != x) e++;
        end
        return e;
    endfunction

    initial begin
        int n;
        int w0;
        int d0;
        checks       = 0;
        fails        = 0;
        wcnt         = 0;
        dcnt         = 0;
        reset        = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_wdata    = 8'h00;
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
        step();
        step();
        chk("rst_active", 32'(dma_active), 32'h0);
        chk("rst_done", 32'(dma_done), 32'h0);
        chk("rst_mem_strobes", 32'({mem_read_en, mem_write_en}), 32'h0);
        reset = 1'b1;
        step();
        cpu_addr    = 16'hFF46;
        cpu_read_en = 1'b1;
        #1;
        chk("rst_reg_read", 32'(cpu_rdata), 32'h00);
        cpu_read_en = 1'b0;

        // Load source pages through the idle pass-through path.
        for (int i = 0; i < 160; i++) cpu_wr(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 160; i++) cpu_wr(16'hD000 + 16'(i), 8'(i) ^ 8'hA5);
        for (int i = 0; i < 160; i++) cpu_wr(16'hD100 + 16'(i), 8'(i) + 8'd3);
        chk("idle_passthru_wr", 32'(mem[16'hD105]), 32'h08);
        cpu_addr    = 16'hC007;
        cpu_read_en = 1'b1;
        #1;
        chk("idle_passthru_rd", 32'(cpu_rdata), 32'h5D);
        cpu_read_en = 1'b0;

        // Reset in the middle of READ at idx 37.
        cpu_wr(16'hFF46, 8'hC0);
        repeat (75) step();
        chk("mid_read_addr", 32'(mem_addr), 32'hC025);
        chk("mid_read_en", 32'(mem_read_en), 32'h1);
        reset = 1'b0;
        #1;
        chk("abort_active", 32'(dma_active), 32'h0);
        chk("abort_no_we", 32'(mem_write_en), 32'h0);
        w0 = wcnt;
        repeat (3) step();
        reset = 1'b1;
        repeat (20) step();
        chk("abort_no_writes", 32'(wcnt - w0), 32'h0);
        cpu_addr    = 16'hFF46;
        cpu_read_en = 1'b1;
        #1;
        chk("abort_reg_read", 32'(cpu_rdata), 32'h00);
        cpu_read_en = 1'b0;

        // Full copy from C000.
        d0 = dcnt;
        cpu_wr(16'hFF46, 8'hC0);
        chk("start_active", 32'(dma_active), 32'h1);
        chk("start_quiet", 32'({mem_read_en, mem_write_en}), 32'h0);
        run_to_done(n);
        chk("full_done_edges", 32'(n), 32'd321);
        chk("full_idle", 32'(dma_active), 32'h0);
        step();
        chk("full_done_width", 32'(dma_done), 32'h0);
        chk("full_done_count", 32'(dcnt - d0), 32'h1);
        chk("full_oam", 32'(oam_errs(0)), 32'h0);
        cpu_addr    = 16'hFF46;
        cpu_read_en = 1'b1;
        #1;
        chk("full_reg_read", 32'(cpu_rdata), 32'hC0);
        cpu_read_en = 1'b0;

        // Echo source F1 -> D1; blocked CPU read and write mid-transfer.
        cpu_wr(16'hFF46, 8'hF1);
        repeat (5) step();
        cpu_addr    = 16'h0150;
        cpu_read_en = 1'b1;
        #1;
        chk("blk_rd_data", 32'(cpu_rdata), 32'hFF);
        chk("blk_rd_dma_addr", 32'(mem_addr), 32'hD102);
        chk("blk_rd_dma_re", 32'(mem_read_en), 32'h1);
        step();
        cpu_read_en  = 1'b0;
        cpu_addr     = 16'hC123;
        cpu_wdata    = 8'h99;
        cpu_write_en = 1'b1;
        #1;
        chk("blk_wr_dma_addr", 32'(mem_addr), 32'hFE02);
        chk("blk_wr_dma_data", 32'(mem_wdata), 32'h05);
        step();
        cpu_write_en = 1'b0;
        chk("blk_wr_dropped", 32'(mem[16'hC123]), 32'h00);
        run_to_done(n);
        chk("echo_done_edges", 32'(n + 7), 32'd321);
        chk("echo_oam", 32'(oam_errs(2)), 32'h0);

        // HRAM writes steal three cycles.
        cpu_wr(16'hFF46, 8'hC0);
        repeat (3) step();
        cpu_addr     = 16'hFF90;
        cpu_wdata    = 8'h77;
        cpu_write_en = 1'b1;
        #1;
        chk("hram_addr", 32'(mem_addr), 32'hFF90);
        chk("hram_we", 32'(mem_write_en), 32'h1);
        repeat (3) step();
        cpu_write_en = 1'b0;
        #1;
        chk("hram_resume_addr", 32'(mem_addr), 32'hC001);
        chk("hram_data", 32'(mem[16'hFF90]), 32'h77);
        run_to_done(n);
        chk("hram_done_edges", 32'(n + 6), 32'd324);
        chk("hram_oam", 32'(oam_errs(0)), 32'h0);
        step();

        // Restart at idx 50 with source D0.
        d0 = dcnt;
        cpu_wr(16'hFF46, 8'hC0);
        repeat (101) step();
        cpu_addr     = 16'hFF46;
        cpu_wdata    = 8'hD0;
        cpu_write_en = 1'b1;
        #1;
        chk("rs_read_addr", 32'(mem_addr), 32'hC032);
        chk("rs_read_en", 32'(mem_read_en), 32'h1);
        step();
        cpu_write_en = 1'b0;
        #1;
        chk("rs_start_quiet", 32'({dma_active, mem_read_en, mem_write_en}), 32'h4);
        step();
        chk("rs_first_addr", 32'(mem_addr), 32'hD000);
        run_to_done(n);
        chk("rs_done_edges", 32'(n + 1), 32'd321);
        step();
        chk("rs_done_count", 32'(dcnt - d0), 32'h1);
        chk("rs_oam", 32'(oam_errs(1)), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
